// File: rtl/crc_pkg.sv
// crc_pkg: shared types, standard polynomials and reference helpers for the
// streaming CRC engine.
//   crc_state_t  : engine FSM states (IDLE, SHIFT, DONE)
//   POLY_*       : common generator polynomials, implicit top bit omitted
//   crc_fold     : MSB-first Galois fold on a register left-aligned in 32 bits
//   bit_reverse  : reverse the low 'width' bits of a 32-bit value
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

  localparam logic [31:0] POLY_CRC8_31     = 32'h0000_0031;
  localparam logic [31:0] POLY_CRC16_CCITT = 32'h0000_1021;
  localparam logic [31:0] POLY_CRC32       = 32'h04C1_1DB7;

  // crc and poly are left-aligned (register MSB at bit 31) so one routine
  // serves every width; bits are consumed from bits[n-1] down to bits[0].
  function automatic logic [31:0] crc_fold(input logic [31:0] crc,
                                           input logic [31:0] bits,
                                           input int          n,
                                           input logic [31:0] poly);
    logic [31:0] r;
    logic        fb;
    r = crc;
    for (int i = 31; i >= 0; i--) begin
      if (i < n) begin
        fb = r[31] ^ bits[i];
        r  = {r[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      end
    end
    return r;
  endfunction

  // Reverse all 32 bits, then slide the field back down to bit 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int          width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = value[31-i];
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: combinational multi-bit LFSR update.
// Applies BITS MSB-first Galois steps to crc_in; bits[BITS-1] is folded first.
//   crc_in   in  CRC_W  current register value
//   bits     in  BITS   data bits for this clock, first-consumed bit at MSB
//   crc_next out CRC_W  register after BITS steps
module crc_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h31,
  parameter int               BITS  = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BITS-1:0]  bits,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] acc;
  logic             fb;

  always_comb begin
    acc = crc_in;
    fb  = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      fb  = acc[CRC_W-1] ^ bits[BITS-1-i];
      acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised streaming CRC generator/checker.
// Accepts DATA_W-bit words over valid/ready and folds BITS_PER_CLK bits per
// clock into the CRC register; reports the finished CRC and a residue match.
//   clk, rst          clock and asynchronous active-high reset
//   abort             synchronous frame abort (highest priority)
//   in_valid/in_ready word handshake; in_ready only in IDLE
//   in_data           input word
//   in_sof / in_last  frame delimiters (sof reloads INIT on accept)
//   crc_valid         one-cycle pulse when crc_out/crc_ok are final
//   crc_out           reflected/XORed CRC, held until the next sof accept
//   crc_ok            raw register matched RESIDUE at frame end
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W        = 8,
  parameter logic [31:0] POLY         = POLY_CRC8_31,
  parameter logic [31:0] INIT         = 32'hFF,
  parameter bit          REFIN        = 1'b1,
  parameter bit          REFOUT       = 1'b0,
  parameter logic [31:0] XOROUT       = 32'h00,
  parameter logic [31:0] RESIDUE      = 32'h00,
  parameter int          DATA_W       = 8,
  parameter int          BITS_PER_CLK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_last,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok
);

  localparam int               STEPS     = DATA_W / BITS_PER_CLK;
  localparam int               CNT_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STEPS - 1);
  localparam logic [CRC_W-1:0] POLY_T    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_T    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_T  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_T = RESIDUE[CRC_W-1:0];

  crc_state_t        state_reg;
  logic [CRC_W-1:0]  crc_reg;
  logic [DATA_W-1:0] data_reg;
  logic              last_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [DATA_W-1:0] data_rev;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  crc_next_rev;
  logic [CRC_W-1:0]  crc_final;

  // Reflected input is stored reversed so the shifter always feeds MSB first.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data_rev
      assign data_rev[gi] = in_data[DATA_W-1-gi];
    end
    for (gi = 0; gi < CRC_W; gi++) begin : g_crc_rev
      assign crc_next_rev[gi] = crc_next[CRC_W-1-gi];
    end
  endgenerate

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY_T),
    .BITS  (BITS_PER_CLK)
  ) u_step (
    .crc_in   (crc_reg),
    .bits     (data_reg[DATA_W-1 -: BITS_PER_CLK]),
    .crc_next (crc_next)
  );

  // Outputs are captured from the final fold result on the edge that enters DONE.
  assign crc_final = (REFOUT ? crc_next_rev : crc_next) ^ XOROUT_T;
  assign in_ready  = (state_reg == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      crc_reg   <= INIT_T;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
    end else if (abort) begin
      // Abort wins over any concurrent accept; results from earlier frames stay.
      state_reg <= IDLE;
      crc_reg   <= INIT_T;
      cnt_reg   <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= REFIN ? data_rev : in_data;
            last_reg  <= in_last;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
            if (in_sof) begin
              crc_reg <= INIT_T;
              crc_ok  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          crc_reg  <= crc_next;
          data_reg <= data_reg << BITS_PER_CLK;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            if (last_reg) begin
              state_reg <= DONE;
              crc_valid <= 1'b1;
              crc_out   <= crc_final;
              crc_ok    <= (crc_next == RESIDUE_T);
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: six differently configured instances
// share one stimulus bus; a select gates in_valid to the instance under test.
//   0: CRC-8/NRSC-5 (REFIN=0), 1/2/3: CRC-8/MAXIM at 1/4/8 bits per clock,
//   4: CRC-16/CCITT-FALSE on bytes, 5: same on 16-bit words with INIT set to
//      the register value after the byte "1" (so "23456789" gives 'h29B1).
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        vld = 1'b0;
  logic        sof = 1'b0;
  logic        last = 1'b0;
  logic [15:0] din = '0;
  int          sel = 0;

  logic [5:0]  rdy, cv, ok;
  logic [7:0]  c0, c1, c2, c3;
  logic [15:0] c4, c5;

  int tests = 0;
  int failed = 0;
  int tot [6];

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(8), .POLY(32'h31), .INIT(32'hFF), .REFIN(1'b0), .REFOUT(1'b0),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8), .BITS_PER_CLK(1)) u0 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 0)), .in_ready(rdy[0]),
    .in_data(din[7:0]), .in_sof(sof), .in_last(last), .crc_valid(cv[0]), .crc_out(c0), .crc_ok(ok[0]));

  crc_stream_engine #(.CRC_W(8), .POLY(32'h31), .INIT(32'h00), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8), .BITS_PER_CLK(1)) u1 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 1)), .in_ready(rdy[1]),
    .in_data(din[7:0]), .in_sof(sof), .in_last(last), .crc_valid(cv[1]), .crc_out(c1), .crc_ok(ok[1]));

  crc_stream_engine #(.CRC_W(8), .POLY(32'h31), .INIT(32'h00), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8), .BITS_PER_CLK(4)) u2 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 2)), .in_ready(rdy[2]),
    .in_data(din[7:0]), .in_sof(sof), .in_last(last), .crc_valid(cv[2]), .crc_out(c2), .crc_ok(ok[2]));

  crc_stream_engine #(.CRC_W(8), .POLY(32'h31), .INIT(32'h00), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8), .BITS_PER_CLK(8)) u3 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 3)), .in_ready(rdy[3]),
    .in_data(din[7:0]), .in_sof(sof), .in_last(last), .crc_valid(cv[3]), .crc_out(c3), .crc_ok(ok[3]));

  crc_stream_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8), .BITS_PER_CLK(1)) u4 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 4)), .in_ready(rdy[4]),
    .in_data(din[7:0]), .in_sof(sof), .in_last(last), .crc_valid(cv[4]), .crc_out(c4), .crc_ok(ok[4]));

  crc_stream_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hC782), .REFIN(1'b0), .REFOUT(1'b0),
    .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(16), .BITS_PER_CLK(1)) u5 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(vld && (sel == 5)), .in_ready(rdy[5]),
    .in_data(din), .in_sof(sof), .in_last(last), .crc_valid(cv[5]), .crc_out(c5), .crc_ok(ok[5]));

  // Pulse counters; sampled on the rising edge so each one-cycle pulse counts once.
  always @(posedge clk) begin
    for (int k = 0; k < 6; k++) if (cv[k]) tot[k] = tot[k] + 1;
  end

  typedef struct {
    int          inst;
    int          len;
    logic [79:0] data;
    bit          sof;
    logic [15:0] crc;
    bit          ok;
    int          busy;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  function automatic logic [15:0] crc_of(input int k);
    case (k)
      0: return {8'h00, c0};
      1: return {8'h00, c1};
      2: return {8'h00, c2};
      3: return {8'h00, c3};
      4: return c4;
      default: return c5;
    endcase
  endfunction

  function automatic logic [15:0] word_of(input logic [79:0] d, input int i, input int k);
    if (k == 5) return d[79-16*i -: 16];
    return {8'h00, d[79-8*i -: 8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    failed++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input int k, input logic [15:0] w, input bit s, input bit l);
    int n;
    n = 0;
    while (!rdy[k] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("send_ready");
    sel = k; din = w; sof = s; last = l; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0; sof = 1'b0; last = 1'b0;
  endtask

  task automatic wait_ready(input int k, output int n);
    n = 0;
    while (!rdy[k] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("wait_ready");
  endtask

  task automatic wait_pulse(input int k, output int n);
    n = 0;
    while (!cv[k] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("wait_pulse");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, base;
    logic [15:0] got_crc;
    logic        got_ok;

    vec[0]  = '{0, 9,  {"123456789", 8'h00}, 1'b1, 16'h00F7, 1'b0, 8};
    vec[1]  = '{0, 10, {"123456789", 8'hF7}, 1'b1, 16'h0000, 1'b1, 8};
    vec[2]  = '{0, 10, {"123456789", 8'hF6}, 1'b1, 16'h0031, 1'b0, 8};
    vec[3]  = '{1, 9,  {"123456789", 8'h00}, 1'b1, 16'h00A1, 1'b0, 8};
    vec[4]  = '{2, 9,  {"123456789", 8'h00}, 1'b1, 16'h00A1, 1'b0, 2};
    vec[5]  = '{3, 9,  {"123456789", 8'h00}, 1'b1, 16'h00A1, 1'b0, 1};
    vec[6]  = '{4, 9,  {"123456789", 8'h00}, 1'b1, 16'h29B1, 1'b0, 8};
    vec[7]  = '{5, 4,  {"23456789", 16'h0000}, 1'b1, 16'h29B1, 1'b0, 16};
    vec[8]  = '{0, 1,  {8'hFF, 72'h0}, 1'b1, 16'h0000, 1'b1, 0};
    vec[9]  = '{0, 1,  {8'h00, 72'h0}, 1'b1, 16'h00AC, 1'b0, 0};
    vec[10] = '{0, 1,  {8'h00, 72'h0}, 1'b0, 16'h0081, 1'b0, 0};

    // Reset state.
    #2;
    check("reset_ready", {26'h0, rdy}, 32'h3F);
    check("reset_valid", {26'h0, cv}, 32'h0);
    check("reset_crc_out", {16'h0, crc_of(0)}, 32'h0);
    check("reset_crc_ok", {26'h0, ok}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames.
    for (int v = 0; v < NV; v++) begin
      k = vec[v].inst;
      base = tot[k];
      for (int i = 0; i < vec[v].len; i++) begin
        send(k, word_of(vec[v].data, i, k), vec[v].sof && (i == 0), i == vec[v].len - 1);
        if (i == 0 && vec[v].busy != 0) begin
          wait_ready(k, n);
          check($sformatf("v%0d_busy", v), n, vec[v].busy);
        end
      end
      wait_pulse(k, n);
      got_crc = crc_of(k);
      got_ok  = ok[k];
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_crc", v), {16'h0, got_crc}, {16'h0, vec[v].crc});
      check($sformatf("v%0d_ok", v), {31'h0, got_ok}, {31'h0, vec[v].ok});
      check($sformatf("v%0d_pulses", v), tot[k] - base, 1);
      $display("[TB] vec %0d inst %0d words %0d crc=%h ok=%b", v, k, vec[v].len, got_crc, got_ok);
    end

    // Latency of a one-word frame, then crc_out hold / crc_ok clear on sof.
    send(0, 16'h00FF, 1'b1, 1'b1);
    wait_pulse(0, n);
    check("latency_cycles", n, 8);
    check("ff_crc", {24'h0, c0}, 32'h00);
    check("ff_ok", {31'h0, ok[0]}, 32'h1);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, cv[0]}, 32'h0);
    send(0, 16'h0055, 1'b1, 1'b0);
    check("sof_clears_ok", {31'h0, ok[0]}, 32'h0);
    check("sof_holds_crc", {24'h0, c0}, 32'h00);
    $display("[TB] hold: crc_out=%h crc_ok=%b after sof accept", c0, ok[0]);
    wait_ready(0, n);

    // Abort in the third SHIFT cycle: no pulse, register back to INIT.
    base = tot[0];
    send(0, 16'h0000, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", {31'h0, rdy[0]}, 32'h1);
    repeat (20) @(negedge clk);
    check("abort_no_pulse", tot[0] - base, 0);
    send(0, 16'h0000, 1'b0, 1'b1);
    wait_pulse(0, n);
    check("after_abort_crc", {24'h0, c0}, 32'hAC);
    $display("[TB] abort: no pulse, next frame crc=%h", c0);
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges in the middle of SHIFT.
    base = tot[0];
    send(0, 16'h00FF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", {31'h0, rdy[0]}, 32'h1);
    check("midrst_valid", {31'h0, cv[0]}, 32'h0);
    check("midrst_crc_out", {24'h0, c0}, 32'h0);
    check("midrst_ok", {31'h0, ok[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_pulse", tot[0] - base, 0);
    send(0, 16'h0000, 1'b1, 1'b1);
    wait_pulse(0, n);
    check("after_rst_crc", {24'h0, c0}, 32'hAC);
    $display("[TB] reset mid-shift: next frame crc=%h", c0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
